// File: rtl/instr_exec_ctrl.sv
// Three-cycle instruction executor (IDLE/READ/EXEC) with a 32x32 register file and program counter.
// Statistics counters are built only when INSTR_EXEC_STATS_EN is defined; otherwise the ports read zero.
module instr_exec_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr_data,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] pc_o,
  output logic        busy,
  output logic        done,
  output logic [15:0] instr_cnt,
  output logic [15:0] jmp_taken_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] instr_q;
  logic [31:0] rf [0:31];
  logic [31:0] op1_q, op2_q;
  logic [31:0] pc_q;
  logic        accept;

  logic        is_jmp, is_cond;
  logic [4:0]  reg1, reg2, regd;
  logic [1:0]  cc;
  logic [31:0] addr_ext;

  assign is_jmp   = instr_q[15];
  assign is_cond  = instr_q[12];
  assign reg1     = instr_q[14:10];
  assign reg2     = instr_q[9:5];
  assign regd     = instr_q[4:0];
  assign cc       = instr_q[11:10];
  assign addr_ext = {22'd0, instr_q[9:0]};

  // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
  // ready is offered only in IDLE while no load is requested, so a load wins the cycle.
  assign instr_ready = (state == IDLE) && !ld_en;
  assign accept      = instr_valid && instr_ready;

  assign busy      = (state != IDLE);
  assign done      = (state == EXEC);
  assign pc_o      = pc_q;
  assign dbg_data  = rf[dbg_addr];
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_q <= 16'h0000;
    else if (accept) instr_q <= instr_data;
  end

  // JmpC reuses op1 for its condition register so EXEC has a single operand path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= 32'h0;
      op2_q <= 32'h0;
    end else if (state == READ) begin
      op1_q <= is_jmp ? rf[{3'b000, cc}] : rf[reg1];
      op2_q <= rf[reg2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if ((state == IDLE) && ld_en) begin
      rf[ld_addr] <= ld_data;
    end else if ((state == EXEC) && !is_jmp && (regd != 5'd0)) begin
      rf[regd] <= op1_q + op2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else if (state == EXEC) begin
      if (!is_jmp)             pc_q <= pc_q + 32'd1;
      else if (!is_cond)       pc_q <= pc_q + addr_ext;
      else if (op1_q != 32'h0) pc_q <= addr_ext;
      else                     pc_q <= pc_q + 32'd1;
    end
  end

`ifdef INSTR_EXEC_STATS_EN
  logic        jmp_taken;
  logic [15:0] instr_cnt_q, jmp_cnt_q;

  assign jmp_taken = is_jmp && (!is_cond || (op1_q != 32'h0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q <= 16'h0000;
      jmp_cnt_q   <= 16'h0000;
    end else if (state == EXEC) begin
      if (instr_cnt_q != 16'hFFFF)            instr_cnt_q <= instr_cnt_q + 16'd1;
      if (jmp_taken && (jmp_cnt_q != 16'hFFFF)) jmp_cnt_q <= jmp_cnt_q + 16'd1;
    end
  end

  assign instr_cnt     = instr_cnt_q;
  assign jmp_taken_cnt = jmp_cnt_q;
`else
  assign instr_cnt     = 16'h0000;
  assign jmp_taken_cnt = 16'h0000;
`endif

endmodule

// File: doc/instr_exec_ctrl.md
INSTR_EXEC_CTRL -- requirements
Module: instr_exec_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the pc_o value after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid, input, 1 bit: instr_data holds an instruction.
REQ-005 SHALL have port instr_ready, output, 1 bit: block can accept an instruction this cycle.
REQ-006 SHALL have port instr_data, input, 16 bits: encoded instruction, see REQ-017.
REQ-007 SHALL have port ld_en, input, 1 bit: register-file load strobe.
REQ-008 SHALL have ports ld_addr (input, 5 bits) and ld_data (input, 32 bits): load target and value.
REQ-009 SHALL have ports dbg_addr (input, 5 bits) and dbg_data (output, 32 bits): combinational register-file read.
REQ-010 SHALL have port pc_o, output, 32 bits: program counter.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-013 SHALL have ports instr_cnt and jmp_taken_cnt, both output, 16 bits: statistics, see REQ-030.

Function
REQ-014 SHALL contain a 32 x 32-bit register file rf[0:31].
REQ-015 SHALL implement a three-state FSM: IDLE, READ, EXEC.
- IDLE->READ on accept.
- READ->EXEC unconditionally.
- EXEC->IDLE unconditionally.
REQ-016 SHALL assert instr_ready only in IDLE with ld_en low; accept = instr_valid && instr_ready; on accept, capture instr_data.
REQ-017 SHALL decode the captured word as follows.
- bit15 = 0 (Add): reg1 = [14:10], reg2 = [9:5], regd = [4:0].
- bit15 = 1 (Jmp): bit12 = 0 (JmpU): addr = [9:0].
- bit15 = 1 (Jmp): bit12 = 1 (JmpC): cc = [11:10], addr = [9:0].
- bits [14:13] are ignored for Jmp.
REQ-018 SHALL, in READ, latch the operands: rf[reg1] and rf[reg2] for Add; rf[cc] for JmpC.
REQ-019 SHALL, in EXEC, perform the operation.
- Add with regd != 0: rf[regd] <= operand1 + operand2, modulo 2^32, and pc_o <= pc_o + 1.
- Add with regd == 0: no register write; pc_o <= pc_o + 1.
REQ-020 SHALL, in EXEC, execute JmpU as pc_o <= pc_o + zero-extended addr, modulo 2^32.
REQ-021 SHALL, in EXEC, execute JmpC as follows: latched rf[cc] != 0 gives pc_o <= zero-extended addr (taken); otherwise pc_o <= pc_o + 1.
REQ-022 SHALL pulse done high for exactly the EXEC cycle; results are visible on dbg_data and pc_o from the cycle after EXEC.
REQ-023 SHALL give an accept-to-next-accept latency of 3 cycles minimum, i.e. one instruction per 3 cycles.
REQ-024 SHALL, when ld_en is high in IDLE, write rf[ld_addr] <= ld_data (including address 0); ld_en outside IDLE is ignored.
REQ-025 SHALL give ld_en priority over instr_valid in the same IDLE cycle: the load occurs and no instruction is accepted.
REQ-026 SHALL let the READ latch see the updated value when an instruction reads a register written by the preceding instruction (no stale data).

Reset
REQ-027 SHALL, on rst high and regardless of clk, force the following immediately.
- FSM to IDLE; pending instruction discarded.
- pc_o = PC_RESET.
- All rf entries = 0.
- done = 0, busy = 0.
- instr_cnt = 0, jmp_taken_cnt = 0.
REQ-028 SHALL drive instr_ready = 1 while rst is high, provided ld_en is low; accepts are ignored until rst deasserts.
REQ-029 SHALL, when rst asserts mid-instruction (READ or EXEC), perform no register-file write and no pc update for that instruction.

Configuration
REQ-030 SHALL, with macro INSTR_EXEC_STATS_EN defined, update the statistics counters in each EXEC cycle, both saturating at 16'hFFFF.
- instr_cnt increments on every retired instruction.
- jmp_taken_cnt increments on every JmpU and on every taken JmpC.
REQ-031 SHALL, without INSTR_EXEC_STATS_EN, keep both counter ports present and tied to 16'h0000, with no counter logic.

Verification
REQ-032 SHALL cover Add: load rf[1] = 5, rf[2] = 7; send 16'h0443 (Add r1, r2, rd = 3) -> done pulses 3 cycles after accept, rf[3] = 12, pc_o = 1.
REQ-033 SHALL cover Add to r0 with wrap-around.
- Load rf[1] = 32'hFFFF_FFFF, rf[2] = 2; send Add rd = 0 -> rf[0] unchanged at 0, pc_o +1.
- Then send Add rd = 4 -> rf[4] = 1.
REQ-034 SHALL cover JmpU: pc_o = 10; send 16'h8005 -> pc_o = 15; with STATS, jmp_taken_cnt = 1.
REQ-035 SHALL cover JmpC.
- rf[2] = 0: send 16'h9A40 (cc = 2, addr = 0x240) -> pc_o +1, not taken.
- rf[2] = 9: repeat -> pc_o = 32'h240.
REQ-036 SHALL cover handshake and priority.
- instr_valid held high continuously -> accepts every 3rd cycle, instr_ready low in READ/EXEC.
- ld_en and instr_valid high together in IDLE -> load occurs, no accept.
REQ-037 SHALL cover reset during EXEC of Add rd = 3: assert rst -> rf[3] = 0, pc_o = PC_RESET, done low, FSM in IDLE.
